// File: rtl/unidade_controle_vidas_if.sv
// Signal bundle between the memory-game control unit and the datapath/top level.
// Inputs to the FSM are iniciar/modo (levels), jogada (single-cycle pulse) and the datapath flags.
interface unidade_controle_vidas_if #(
  parameter int MAX_VIDAS = 3
);
  localparam int VW = $clog2(MAX_VIDAS + 1);

  logic          iniciar;
  logic          modo;
  logic          jogada;
  logic          botoesIgualMemoria;
  logic          fimL;
  logic          enderecoIgualLimite;
  logic          enderecoMenorLimite;
  logic          zeraE;
  logic          contaE;
  logic          zeraL;
  logic          contaL;
  logic          zeraR;
  logic          registraR;
  logic          acende_leds;
  logic          acertou;
  logic          errou;
  logic          timeout;
  logic          pronto;
  logic [VW-1:0] vidas;
  logic [3:0]    db_estado;

  modport master (
    output iniciar, modo, jogada, botoesIgualMemoria, fimL,
           enderecoIgualLimite, enderecoMenorLimite,
    input  zeraE, contaE, zeraL, contaL, zeraR, registraR, acende_leds,
           acertou, errou, timeout, pronto, vidas, db_estado
  );

  modport slave (
    input  iniciar, modo, jogada, botoesIgualMemoria, fimL,
           enderecoIgualLimite, enderecoMenorLimite,
    output zeraE, contaE, zeraL, contaL, zeraR, registraR, acende_leds,
           acertou, errou, timeout, pronto, vidas, db_estado
  );
endinterface

// File: rtl/unidade_controle_vidas.sv
// Moore control FSM for the memory game: optional sequence display, play timeout
// and a lives counter that replays the current round after a miss.
module unidade_controle_vidas #(
  parameter int TIMEOUT_CICLOS   = 5000,
  parameter int HABILITA_TIMEOUT = 1,
  parameter int MOSTRA_CICLOS    = 1000,
  parameter int MAX_VIDAS        = 3
) (
  input logic                     clock,
  input logic                     reset,
  unidade_controle_vidas_if.slave bus
);
  localparam int VW = $clog2(MAX_VIDAS + 1);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam int MW = $clog2(MOSTRA_CICLOS + 1);

  typedef enum logic [3:0] {
    INICIAL          = 4'h0,
    PREPARACAO       = 4'h1,
    INICIA_SEQUENCIA = 4'h2,
    MOSTRA_LED       = 4'h3,
    APAGA_LED        = 4'h4,
    FIM_MOSTRA       = 4'h5,
    ESPERA_JOGADA    = 4'h6,
    REGISTRA_JOGADA  = 4'h7,
    COMPARA_JOGADA   = 4'h8,
    PROXIMA_JOGADA   = 4'h9,
    FOI_ULTIMA_SEQ   = 4'hA,
    PROXIMA_SEQ      = 4'hB,
    PERDE_VIDA       = 4'hC,
    FINAL_TIMEOUT    = 4'hD,
    FINAL_ACERTOU    = 4'hE,
    FINAL_ERROU      = 4'hF
  } estado_t;

  estado_t       r_estado;
  estado_t       w_prox;
  logic [TW-1:0] r_t;
  logic [MW-1:0] r_s;
  logic [VW-1:0] r_vidas;
  logic          r_modo;
  logic          w_expira;
  logic          w_fim_s;
  logic          w_em_mostra;
  logic          w_mais_vidas;

  assign w_em_mostra  = (r_estado == MOSTRA_LED) || (r_estado == APAGA_LED);
  assign w_fim_s      = w_em_mostra && (r_s == MW'(MOSTRA_CICLOS - 1));
  assign w_expira     = (HABILITA_TIMEOUT != 0) && (r_estado == ESPERA_JOGADA) &&
                        (r_t == TW'(TIMEOUT_CICLOS - 1));
  assign w_mais_vidas = (r_vidas > VW'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= INICIAL;
      r_t      <= '0;
      r_s      <= '0;
      r_vidas  <= VW'(MAX_VIDAS);
      r_modo   <= 1'b0;
    end else begin
      r_estado <= w_prox;
      // T saturates at its terminal value so a disabled timeout never wraps.
      if (r_estado != ESPERA_JOGADA) r_t <= '0;
      else if (r_t != TW'(TIMEOUT_CICLOS - 1)) r_t <= r_t + TW'(1);
      if (w_em_mostra && !w_fim_s) r_s <= r_s + MW'(1);
      else r_s <= '0;
      if (r_estado == PREPARACAO) begin
        r_vidas <= VW'(MAX_VIDAS);
        r_modo  <= bus.modo;
      end else if (w_prox == PERDE_VIDA && r_estado != PERDE_VIDA && w_mais_vidas) begin
        r_vidas <= r_vidas - VW'(1);
      end
    end
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      INICIAL:          if (bus.iniciar) w_prox = PREPARACAO;
      PREPARACAO:       w_prox = INICIA_SEQUENCIA;
      INICIA_SEQUENCIA: w_prox = r_modo ? MOSTRA_LED : ESPERA_JOGADA;
      MOSTRA_LED:       if (w_fim_s) w_prox = APAGA_LED;
      APAGA_LED:        if (w_fim_s) w_prox = bus.enderecoIgualLimite ? FIM_MOSTRA : MOSTRA_LED;
      FIM_MOSTRA:       w_prox = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        // A press on the expiry cycle still counts as a play.
        if (bus.jogada)    w_prox = REGISTRA_JOGADA;
        else if (w_expira) w_prox = w_mais_vidas ? PERDE_VIDA : FINAL_TIMEOUT;
      end
      REGISTRA_JOGADA:  w_prox = COMPARA_JOGADA;
      COMPARA_JOGADA: begin
        if (bus.botoesIgualMemoria && bus.enderecoMenorLimite)      w_prox = PROXIMA_JOGADA;
        else if (bus.botoesIgualMemoria && bus.enderecoIgualLimite) w_prox = FOI_ULTIMA_SEQ;
        else w_prox = w_mais_vidas ? PERDE_VIDA : FINAL_ERROU;
      end
      PROXIMA_JOGADA:   w_prox = ESPERA_JOGADA;
      FOI_ULTIMA_SEQ:   w_prox = bus.fimL ? FINAL_ACERTOU : PROXIMA_SEQ;
      PROXIMA_SEQ:      w_prox = INICIA_SEQUENCIA;
      PERDE_VIDA:       w_prox = INICIA_SEQUENCIA;
      FINAL_TIMEOUT, FINAL_ACERTOU, FINAL_ERROU:
                        if (bus.iniciar) w_prox = PREPARACAO;
    endcase
  end

  always_comb begin
    bus.zeraE       = 1'b0;
    bus.contaE      = 1'b0;
    bus.zeraL       = 1'b0;
    bus.contaL      = 1'b0;
    bus.zeraR       = 1'b0;
    bus.registraR   = 1'b0;
    bus.acende_leds = 1'b0;
    bus.acertou     = 1'b0;
    bus.errou       = 1'b0;
    bus.timeout     = 1'b0;
    bus.pronto      = 1'b0;
    bus.vidas       = r_vidas;
    bus.db_estado   = r_estado;
    case (r_estado)
      INICIAL: begin
        bus.zeraE = 1'b1;
        bus.zeraL = 1'b1;
        bus.zeraR = 1'b1;
      end
      PREPARACAO: begin
        bus.zeraL = 1'b1;
        bus.zeraR = 1'b1;
      end
      INICIA_SEQUENCIA: bus.zeraE       = 1'b1;
      FIM_MOSTRA:       bus.zeraE       = 1'b1;
      MOSTRA_LED:       bus.acende_leds = 1'b1;
      APAGA_LED:        bus.contaE      = w_fim_s && !bus.enderecoIgualLimite;
      PROXIMA_JOGADA:   bus.contaE      = 1'b1;
      PROXIMA_SEQ:      bus.contaL      = 1'b1;
      REGISTRA_JOGADA:  bus.registraR   = 1'b1;
      FINAL_TIMEOUT: begin
        bus.timeout = 1'b1;
        bus.pronto  = 1'b1;
      end
      FINAL_ACERTOU: begin
        bus.acertou = 1'b1;
        bus.pronto  = 1'b1;
      end
      FINAL_ERROU: begin
        bus.errou  = 1'b1;
        bus.pronto = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
